inst_ascii_encoder: RTL and testbench
=====================================

# inst_ascii_encoder

Streaming mini-assembler front end: accepts an ASCII byte stream (UART/debug console side) and converts each whitespace-delimited MIPS mnemonic token into a 32-bit instruction template. The template has opcode, funct, and fixed rs/rt fields set, and all operand fields zero. It is the inverse of the pipeline's instruction-to-ASCII debug decoder and sits between the debug byte channel and the instruction-injection / test-ROM loader path. Unknown or malformed tokens produce a flagged, zero-valued result.

## Interface
- MAX_LEN, 7, maximum token length in characters (must be ≥7; buffer is 8*MAX_LEN bits)

- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_data  in  8  ASCII byte
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- inst  out  32  encoded instruction template
- inst_err  out  1  token unknown / overlong / contains illegal character
- inst_valid  out  1  inst/inst_err valid
- inst_ready  in  1  result consumed when inst_valid && inst_ready

## Operation
- Character classes:
  - Delimiter: 0x20, 0x09, 0x0A, 0x0D, ','.
  - Alnum: 'A'-'Z', 'a'-'z' (folded to upper case by −0x20), '0'-'9'.
  - Illegal: anything else.
- FSM states IDLE, ACCUM, SKIP, OUT.
  - IDLE: delimiter ignored. Alnum → store as char 0, len=1, go ACCUM. Illegal → go SKIP, bad=1.
  - ACCUM: alnum with len<MAX_LEN → append, len++. Alnum with len==MAX_LEN → go SKIP, bad=1. Illegal → go SKIP, bad=1. Delimiter → register lookup result, go OUT.
  - SKIP: non-delimiters discarded. Delimiter → register inst=0, inst_err=1, go OUT.
  - OUT: inst_valid=1. On inst_ready → clear buffer/len/bad, go IDLE.
- in_ready = (state != OUT).
- Lookup table. Exact match on whole token; prefixes do not match. Unlisted fields are 0.
  - R-type, op=0, funct: SLL 00, SRL 02, SRA 03, SLLV 04, SRLV 06, SRAV 07, JR 08, JALR 09, SYSCALL 0C, BREAK 0D, MFHI 10, MTHI 11, MFLO 12, MTLO 13, MULT 18, MULTU 19, DIV 1A, DIVU 1B, ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, XOR 26, NOR 27, SLT 2A, SLTU 2B.
  - I/J-type opcode: J 02, JAL 03, BEQ 04, BNE 05, BLEZ 06, BGTZ 07, ADDI 08, ADDIU 09, SLTI 0A, SLTIU 0B, ANDI 0C, ORI 0D, XORI 0E, LUI 0F, LB 20, LH 21, LW 23, LBU 24, LHU 25, SB 28, SH 29, SW 2B.
  - REGIMM, op=01, rt: BLTZ 00, BGEZ 01, BLTZAL 10, BGEZAL 11.
  - COP0: MFC0 0x40000000, MTC0 0x40800000, ERET 0x42000018.
  - NOP 0x00000000, inst_err=0.
- No match → inst=0, inst_err=1.

## Timing
- Reset values: state=IDLE, len=0, bad=0, buffer=0, inst=0, inst_err=0, inst_valid=0, in_ready=1.
- Latency: delimiter accepted at edge N → inst_valid=1 from cycle N+1. Lookup is registered, with no combinational path from in_data to inst.
- inst, inst_err, and inst_valid are held stable while inst_valid && !inst_ready.
- Back-to-back: inst_ready high in cycle N+1 → IDLE at N+2, in_ready=1 at N+2. Throughput is one token per (len+2) cycles minimum.
- Delimiter-only input never produces output.
- Overlong token: the (MAX_LEN+1)th alnum sends the FSM to SKIP. Exactly one error result is emitted at the next delimiter.
- rst asserted in any state, including OUT with result pending, returns to reset values next edge. The pending result is dropped.
- in_valid low in ACCUM/SKIP: state is held, with no timeout.

## Test plan
- Stream "ADDU " with in_valid continuous, inst_ready=1 → single result inst=0x00000021, err=0, inst_valid exactly 1 cycle, 1 cycle after the space is accepted.
- Stream "  bgezal\n" → leading spaces ignored, lower case folded; inst=0x04110000, err=0.
- Stream "ERET,MTC0 NOP\r" → three results in order: 0x42000018, 0x40800000, 0x00000000, all err=0.
- Stream "FOO ", "ADDIUXXX ", "AD$D " → three results, each inst=0, err=1. The overlong token gives exactly one result.
- Backpressure: "SW " with inst_ready=0 for 5 cycles → inst=0xAC000000 held stable, in_ready=0 throughout; a byte offered meanwhile is not consumed and is accepted after the handshake.
- Assert rst for 1 cycle mid-token ("SLT", then reset, then "U ") → single result for "U": inst=0, err=1. No stale "SLTU" result.

Source files
------------

// File: rtl/inst_ascii_encoder_if.sv
// rtl/inst_ascii_encoder_if.sv - byte-in / instruction-template-out handshake bundle
// Byte side:   in_data, in_valid (from source), in_ready (from encoder)
// Result side: inst, inst_err, inst_valid (from encoder), inst_ready (from sink)
interface inst_ascii_encoder_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic        inst_err;
    logic        inst_valid;
    logic        inst_ready;

    // master: byte source and result sink
    modport master (
        output in_data, in_valid, inst_ready,
        input  in_ready, inst, inst_err, inst_valid
    );

    // slave: the encoder itself
    modport slave (
        input  in_data, in_valid, inst_ready,
        output in_ready, inst, inst_err, inst_valid
    );
endinterface

// File: rtl/inst_ascii_encoder.sv
// rtl/inst_ascii_encoder.sv - ASCII MIPS mnemonic tokens to 32-bit instruction templates
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - slave side of inst_ascii_encoder_if (byte stream in, template out)
module inst_ascii_encoder #(
    parameter int MAX_LEN = 7
) (
    input  logic               clk,
    input  logic               rst,
    inst_ascii_encoder_if.slave bus
);

    localparam int LW = $clog2(MAX_LEN + 1);

    typedef logic [8*MAX_LEN-1:0] tok_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_SKIP,
        S_OUT
    } state_e;

    state_e      state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic        bad_q, bad_d;
    tok_t        buf_q, buf_d;
    logic [31:0] inst_q, inst_d;
    logic        inst_err_q, inst_err_d;

    // Character classification of the incoming byte
    logic [7:0] ch;
    logic       is_delim, is_upper, is_lower, is_digit, is_alnum, fire;
    logic [7:0] ch_up;

    assign ch       = bus.in_data;
    assign is_delim = (ch == 8'h20) || (ch == 8'h09) || (ch == 8'h0A) ||
                      (ch == 8'h0D) || (ch == 8'h2C);
    assign is_upper = (ch >= 8'h41) && (ch <= 8'h5A);
    assign is_lower = (ch >= 8'h61) && (ch <= 8'h7A);
    assign is_digit = (ch >= 8'h30) && (ch <= 8'h39);
    assign is_alnum = is_upper || is_lower || is_digit;
    assign ch_up    = is_lower ? (ch - 8'h20) : ch;
    assign fire     = bus.in_valid && (state_q != S_OUT);

    function automatic logic [32:0] rtype(input logic [5:0] funct);
        return {1'b0, 26'd0, funct};
    endfunction

    function automatic logic [32:0] itype(input logic [5:0] op);
        return {1'b0, op, 26'd0};
    endfunction

    function automatic logic [32:0] regimm(input logic [4:0] rt);
        return {1'b0, 6'h01, 5'd0, rt, 16'd0};
    endfunction

    // The buffer holds the token right-aligned with zero fill above it, so a
    // zero-extended literal compare is an exact whole-token match: prefixes
    // and extensions of a mnemonic differ in length and never collide.
    // Result is {err, inst}.
    function automatic logic [32:0] lookup(input tok_t t);
        logic [32:0] r;
        r = {1'b1, 32'd0};
        case (t)
            tok_t'("NOP"):     r = {1'b0, 32'h0000_0000};
            tok_t'("SLL"):     r = rtype(6'h00);
            tok_t'("SRL"):     r = rtype(6'h02);
            tok_t'("SRA"):     r = rtype(6'h03);
            tok_t'("SLLV"):    r = rtype(6'h04);
            tok_t'("SRLV"):    r = rtype(6'h06);
            tok_t'("SRAV"):    r = rtype(6'h07);
            tok_t'("JR"):      r = rtype(6'h08);
            tok_t'("JALR"):    r = rtype(6'h09);
            tok_t'("SYSCALL"): r = rtype(6'h0C);
            tok_t'("BREAK"):   r = rtype(6'h0D);
            tok_t'("MFHI"):    r = rtype(6'h10);
            tok_t'("MTHI"):    r = rtype(6'h11);
            tok_t'("MFLO"):    r = rtype(6'h12);
            tok_t'("MTLO"):    r = rtype(6'h13);
            tok_t'("MULT"):    r = rtype(6'h18);
            tok_t'("MULTU"):   r = rtype(6'h19);
            tok_t'("DIV"):     r = rtype(6'h1A);
            tok_t'("DIVU"):    r = rtype(6'h1B);
            tok_t'("ADD"):     r = rtype(6'h20);
            tok_t'("ADDU"):    r = rtype(6'h21);
            tok_t'("SUB"):     r = rtype(6'h22);
            tok_t'("SUBU"):    r = rtype(6'h23);
            tok_t'("AND"):     r = rtype(6'h24);
            tok_t'("OR"):      r = rtype(6'h25);
            tok_t'("XOR"):     r = rtype(6'h26);
            tok_t'("NOR"):     r = rtype(6'h27);
            tok_t'("SLT"):     r = rtype(6'h2A);
            tok_t'("SLTU"):    r = rtype(6'h2B);
            tok_t'("J"):       r = itype(6'h02);
            tok_t'("JAL"):     r = itype(6'h03);
            tok_t'("BEQ"):     r = itype(6'h04);
            tok_t'("BNE"):     r = itype(6'h05);
            tok_t'("BLEZ"):    r = itype(6'h06);
            tok_t'("BGTZ"):    r = itype(6'h07);
            tok_t'("ADDI"):    r = itype(6'h08);
            tok_t'("ADDIU"):   r = itype(6'h09);
            tok_t'("SLTI"):    r = itype(6'h0A);
            tok_t'("SLTIU"):   r = itype(6'h0B);
            tok_t'("ANDI"):    r = itype(6'h0C);
            tok_t'("ORI"):     r = itype(6'h0D);
            tok_t'("XORI"):    r = itype(6'h0E);
            tok_t'("LUI"):     r = itype(6'h0F);
            tok_t'("LB"):      r = itype(6'h20);
            tok_t'("LH"):      r = itype(6'h21);
            tok_t'("LW"):      r = itype(6'h23);
            tok_t'("LBU"):     r = itype(6'h24);
            tok_t'("LHU"):     r = itype(6'h25);
            tok_t'("SB"):      r = itype(6'h28);
            tok_t'("SH"):      r = itype(6'h29);
            tok_t'("SW"):      r = itype(6'h2B);
            tok_t'("BLTZ"):    r = regimm(5'h00);
            tok_t'("BGEZ"):    r = regimm(5'h01);
            tok_t'("BLTZAL"):  r = regimm(5'h10);
            tok_t'("BGEZAL"):  r = regimm(5'h11);
            tok_t'("MFC0"):    r = {1'b0, 32'h4000_0000};
            tok_t'("MTC0"):    r = {1'b0, 32'h4080_0000};
            tok_t'("ERET"):    r = {1'b0, 32'h4200_0018};
            default:           r = {1'b1, 32'd0};
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            bad_q      <= 1'b0;
            buf_q      <= '0;
            inst_q     <= '0;
            inst_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            bad_q      <= bad_d;
            buf_q      <= buf_d;
            inst_q     <= inst_d;
            inst_err_q <= inst_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        bad_d      = bad_q;
        buf_d      = buf_q;
        inst_d     = inst_q;
        inst_err_d = inst_err_q;

        case (state_q)
            S_IDLE: begin
                if (fire && !is_delim) begin
                    if (is_alnum) begin
                        buf_d   = tok_t'(ch_up);
                        len_d   = LW'(1);
                        state_d = S_ACCUM;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = S_SKIP;
                    end
                end
            end
            S_ACCUM: begin
                if (fire) begin
                    if (is_delim) begin
                        {inst_err_d, inst_d} = bad_q ? {1'b1, 32'd0} : lookup(buf_q);
                        state_d = S_OUT;
                    end else if (is_alnum && (len_q != LW'(MAX_LEN))) begin
                        buf_d = {buf_q[8*MAX_LEN-9:0], ch_up};
                        len_d = len_q + LW'(1);
                    end else begin
                        // Overlong or illegal: swallow the rest of the token
                        bad_d   = 1'b1;
                        state_d = S_SKIP;
                    end
                end
            end
            S_SKIP: begin
                if (fire && is_delim) begin
                    inst_d     = '0;
                    inst_err_d = 1'b1;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.inst_ready) begin
                    buf_d   = '0;
                    len_d   = '0;
                    bad_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready   = (state_q != S_OUT);
    assign bus.inst_valid = (state_q == S_OUT);
    assign bus.inst       = inst_q;
    assign bus.inst_err   = inst_err_q;

endmodule

// File: tb/tb_inst_ascii_encoder.sv
// tb/tb_inst_ascii_encoder.sv - scoreboard bench for inst_ascii_encoder
module tb_inst_ascii_encoder;

    localparam int MAX_LEN = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_ascii_encoder_if bus ();

    inst_ascii_encoder #(.MAX_LEN(MAX_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0]  exp_q[$];
    logic [31:0]  tab[string];
    string        names[$];
    string        m_tok = "";
    bit           m_bad = 1'b0;
    bit           rand_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic [31:0] v);
        tab[n] = v;
        names.push_back(n);
    endtask

    task automatic build_table();
        string rn[28] = '{"SLL","SRL","SRA","SLLV","SRLV","SRAV","JR","JALR","SYSCALL","BREAK",
                          "MFHI","MTHI","MFLO","MTLO","MULT","MULTU","DIV","DIVU","ADD","ADDU",
                          "SUB","SUBU","AND","OR","XOR","NOR","SLT","SLTU"};
        int    rf[28] = '{'h00,'h02,'h03,'h04,'h06,'h07,'h08,'h09,'h0C,'h0D,
                          'h10,'h11,'h12,'h13,'h18,'h19,'h1A,'h1B,'h20,'h21,
                          'h22,'h23,'h24,'h25,'h26,'h27,'h2A,'h2B};
        string in[22] = '{"J","JAL","BEQ","BNE","BLEZ","BGTZ","ADDI","ADDIU","SLTI","SLTIU",
                          "ANDI","ORI","XORI","LUI","LB","LH","LW","LBU","LHU","SB","SH","SW"};
        int    io[22] = '{'h02,'h03,'h04,'h05,'h06,'h07,'h08,'h09,'h0A,'h0B,
                          'h0C,'h0D,'h0E,'h0F,'h20,'h21,'h23,'h24,'h25,'h28,'h29,'h2B};
        for (int i = 0; i < 28; i++) add(rn[i], 32'(rf[i]));
        for (int i = 0; i < 22; i++) add(in[i], 32'(io[i]) * 32'h0400_0000);
        add("BLTZ",   32'h0400_0000 + 32'h00 * 32'h1_0000);
        add("BGEZ",   32'h0400_0000 + 32'h01 * 32'h1_0000);
        add("BLTZAL", 32'h0400_0000 + 32'h10 * 32'h1_0000);
        add("BGEZAL", 32'h0400_0000 + 32'h11 * 32'h1_0000);
        add("MFC0",   32'h4000_0000);
        add("MTC0",   32'h4080_0000);
        add("ERET",   32'h4200_0018);
        add("NOP",    32'h0000_0000);
    endtask

    // Token-level reference: collect upper-cased characters as a string and
    // look the whole word up at a delimiter.
    function automatic bit c_delim(input byte c);
        return c == " " || c == 8'h09 || c == 8'h0A || c == 8'h0D || c == ",";
    endfunction

    function automatic bit c_alnum(input byte c);
        return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z") || (c >= "0" && c <= "9");
    endfunction

    task automatic model_byte(input byte c);
        string one;
        if (c_delim(c)) begin
            if (m_bad) exp_q.push_back({1'b1, 32'd0});
            else if (m_tok.len() > 0)
                exp_q.push_back(tab.exists(m_tok) ? {1'b0, tab[m_tok]} : {1'b1, 32'd0});
            m_tok = "";
            m_bad = 1'b0;
        end else if (c_alnum(c)) begin
            if (!m_bad) begin
                if (m_tok.len() == MAX_LEN) m_bad = 1'b1;
                else begin
                    one    = " ";
                    one[0] = (c >= "a" && c <= "z") ? byte'(c - 8'h20) : c;
                    m_tok  = {m_tok, one};
                end
            end
        end else m_bad = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.inst_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_byte(input byte c);
        bit ok;
        bit done;
        done = 1'b0;
        model_byte(c);
        bus.in_data  = c;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            ok = bus.in_ready;
            tick();
            if (ok) done = 1'b1;
        end
        if (!done) chk("byte_accept_timeout", 64'(c), 64'hFFFF);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            if (gaps && $urandom_range(0, 4) == 0) tick();
            send_byte(s[i]);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) tick();
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pops one expectation per accepted result
    always @(negedge clk) begin
        if (!rst && bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", {31'd0, bus.inst_err, bus.inst}, 64'h1_FFFF_FFFF);
            else chk("result", {31'd0, bus.inst_err, bus.inst}, {31'd0, exp_q.pop_front()});
        end
    end

    function automatic string rand_token();
        string s;
        string one;
        int    kind;
        int    n;
        kind = $urandom_range(0, 7);
        s = names[$urandom_range(0, names.size() - 1)];
        if (kind == 5) begin
            if (s.len() > 1 && $urandom_range(0, 1) == 1) s = s.substr(0, s.len() - 2);
            else s = {s, "X"};
        end else if (kind == 6) begin
            s = "";
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                one = " "; one[0] = byte'($urandom_range(65, 90)); s = {s, one};
            end
        end else if (kind == 7) begin
            one = " "; one[0] = "$"; s = {s, one};
        end
        for (int i = 0; i < s.len(); i++)
            if (s[i] >= "A" && s[i] <= "Z" && $urandom_range(0, 1) == 1) s[i] = byte'(s[i] + 8'h20);
        return s;
    endfunction

    function automatic string rand_delims();
        string d = " ";
        string dl = " \t\n\r,";
        int n;
        n = $urandom_range(1, 2);
        d = "";
        for (int i = 0; i < n; i++) d = {d, dl.substr($urandom_range(0, 4), $urandom_range(0, 4) * 0 + 0)};
        return d;
    endfunction

    initial begin
        build_table();
        bus.in_data    = 8'h00;
        bus.in_valid   = 1'b0;
        bus.inst_ready = 1'b1;
        rst = 1'b1;
        tick(); tick();
        chk("rst_in_ready",   64'(bus.in_ready),   64'd1);
        chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        chk("rst_inst",       64'(bus.inst),       64'd0);
        chk("rst_inst_err",   64'(bus.inst_err),   64'd0);
        rst = 1'b0;
        tick();

        // Single token: one-cycle valid, one cycle after the delimiter edge
        send_str("ADDU ", 1'b0);
        chk("addu_latency_valid", 64'(bus.inst_valid), 64'd1);
        chk("addu_value", 64'(bus.inst), 64'h0000_0021);
        tick();
        chk("addu_valid_one_cycle", 64'(bus.inst_valid), 64'd0);
        wait_drain();

        send_str("  bgezal\n", 1'b0);
        wait_drain();
        send_str("ERET,MTC0 NOP\r", 1'b0);
        wait_drain();
        send_str("FOO ADDIUXXX AD$D ", 1'b0);
        wait_drain();

        // Delimiter-only input yields nothing
        send_str(" \t,\r\n  ", 1'b0);
        for (int k = 0; k < 4; k++) tick();
        chk("delims_no_output", 64'(bus.inst_valid), 64'd0);

        // Backpressure
        bus.inst_ready = 1'b0;
        send_str("SW ", 1'b0);
        bus.in_data  = "L";
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", 64'(bus.in_ready),   64'd0);
            chk("bp_valid",    64'(bus.inst_valid), 64'd1);
            chk("bp_inst",     64'(bus.inst),       64'hAC00_0000);
            chk("bp_err",      64'(bus.inst_err),   64'd0);
            tick();
        end
        bus.inst_ready = 1'b1;
        send_str("LW ", 1'b0);
        wait_drain();

        // Reset mid-token drops the partial word
        send_str("SLT", 1'b0);
        rst = 1'b1;
        m_tok = "";
        m_bad = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        send_str("U ", 1'b0);
        wait_drain();

        // Reset while a result is pending drops it
        bus.inst_ready = 1'b0;
        send_str("OR ", 1'b0);
        rst = 1'b1;
        void'(exp_q.pop_back());
        tick();
        rst = 1'b0;
        chk("outrst_valid", 64'(bus.inst_valid), 64'd0);
        bus.inst_ready = 1'b1;

        // Randomized tokens, delimiters, gaps and backpressure
        rand_ready = 1'b1;
        for (int t = 0; t < 250; t++) begin
            string dl;
            string d;
            dl = " \t\n\r,";
            d  = " ";
            d[0] = dl[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) send_str(d, 1'b1);
            send_str(rand_token(), 1'b1);
            send_str(d, 1'b1);
        end
        rand_ready = 1'b0;
        bus.inst_ready = 1'b1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
